// File: rtl/uart_pkg.sv
// Shared types for the UART TX arbiter: frame-sequencer state encoding and a
// constant-safe ceil(log2) helper used to size index and counter fields.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_LAUNCH    = 3'd1,
    ST_WAIT_BUSY = 3'd2,
    ST_WAIT_DONE = 3'd3,
    ST_GAP       = 3'd4
  } state_t;

  // ceil(log2(value)); returns 0 for value <= 1.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

// File: rtl/uart_rr_arbiter.sv
// Round-robin picker: first asserted request at or above ptr (with wrap) wins.
// Purely combinational, no state; the caller owns and advances the pointer.
module uart_rr_arbiter
  import uart_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int IDW   = clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDW-1:0]   ptr,
  output logic [N_REQ-1:0] grant,
  output logic [IDW-1:0]   idx,
  output logic             any_req
);

  logic found;
  int   c;

  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    c     = 0;
    for (int k = 0; k < N_REQ; k++) begin
      c = (int'(ptr) + k) % N_REQ;
      if (!found && req[c[IDW-1:0]]) begin
        found               = 1'b1;
        grant[c[IDW-1:0]]   = 1'b1;
        idx                 = c[IDW-1:0];
      end
    end
  end

  assign any_req = |req;

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART TX among N_REQ byte requesters, round-robin, one frame at a time.
// Launch 1 cycle after a request is seen idle; requesters hold REQ_VALID until REQ_ACK.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int N_REQ        = 4,
  parameter int DATA_WIDTH   = 8,
  parameter int BUSY_TIMEOUT = 8,
  parameter int IFG_CYCLES   = 0
) (
  input  logic                          CLK,
  input  logic                          RST,
  input  logic [N_REQ-1:0]              REQ_VALID,
  input  logic [N_REQ*DATA_WIDTH-1:0]   REQ_DATA,
  output logic [N_REQ-1:0]              REQ_ACK,
  input  logic                          TX_BUSY,
  output logic [DATA_WIDTH-1:0]         TX_P_DATA,
  output logic                          TX_DATA_VALID,
  output logic [clog2(N_REQ)-1:0]       GRANT_ID,
  output logic                          GRANT_ACTIVE,
  output logic                          TIMEOUT_ERR
);

  localparam int IDW = clog2(N_REQ);
  localparam int TW  = clog2(BUSY_TIMEOUT) + 1;
  localparam int GW  = clog2(IFG_CYCLES + 1) + 1;

  localparam logic [TW-1:0]  TO_LAST  = TW'(BUSY_TIMEOUT - 1);
  localparam logic [GW-1:0]  GAP_LAST = GW'((IFG_CYCLES > 0) ? IFG_CYCLES - 1 : 0);
  localparam logic [IDW-1:0] ID_LAST  = IDW'(N_REQ - 1);

  state_t                state, state_nxt;
  logic [IDW-1:0]        ptr;
  logic [N_REQ-1:0]      win_oh;
  logic [IDW-1:0]        win_idx;
  logic                  any_req;

  logic [DATA_WIDTH-1:0] tx_data;
  logic [IDW-1:0]        grant_id;
  logic [N_REQ-1:0]      grant_oh;
  logic [TW-1:0]         to_cnt, to_nxt;
  logic [GW-1:0]         gap_cnt, gap_nxt;
  logic                  timeout_err;
  logic                  take;
  logic                  to_fire;

  uart_rr_arbiter #(
    .N_REQ (N_REQ),
    .IDW   (IDW)
  ) u_rr (
    .req     (REQ_VALID),
    .ptr     (ptr),
    .grant   (win_oh),
    .idx     (win_idx),
    .any_req (any_req)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    take      = 1'b0;
    to_fire   = 1'b0;
    to_nxt    = to_cnt;
    gap_nxt   = gap_cnt;
    case (state)
      ST_IDLE: begin
        // A TX still running (e.g. across our own reset) blocks the next launch.
        if (any_req && !TX_BUSY) begin
          take      = 1'b1;
          state_nxt = ST_LAUNCH;
        end
      end
      ST_LAUNCH: begin
        to_nxt    = '0;
        state_nxt = ST_WAIT_BUSY;
      end
      ST_WAIT_BUSY: begin
        if (TX_BUSY) begin
          state_nxt = ST_WAIT_DONE;
        end else begin
          to_nxt = to_cnt + 1'b1;
          // Counter hitting BUSY_TIMEOUT-1 puts the error pulse exactly BUSY_TIMEOUT cycles after launch.
          if (to_nxt == TO_LAST) begin
            to_fire   = 1'b1;
            state_nxt = ST_IDLE;
          end
        end
      end
      ST_WAIT_DONE: begin
        if (!TX_BUSY) begin
          gap_nxt   = '0;
          state_nxt = (IFG_CYCLES > 0) ? ST_GAP : ST_IDLE;
        end
      end
      ST_GAP: begin
        if (gap_cnt == GAP_LAST) state_nxt = ST_IDLE;
        else                     gap_nxt   = gap_cnt + 1'b1;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      ptr         <= '0;
      tx_data     <= '0;
      grant_id    <= '0;
      grant_oh    <= '0;
      to_cnt      <= '0;
      gap_cnt     <= '0;
      timeout_err <= 1'b0;
    end else begin
      to_cnt      <= to_nxt;
      gap_cnt     <= gap_nxt;
      timeout_err <= to_fire;
      if (take) begin
        tx_data  <= REQ_DATA[win_idx*DATA_WIDTH +: DATA_WIDTH];
        grant_id <= win_idx;
        grant_oh <= win_oh;
        ptr      <= (win_idx == ID_LAST) ? '0 : win_idx + 1'b1;
      end
    end
  end

  assign TX_DATA_VALID = (state == ST_LAUNCH);
  assign REQ_ACK       = (state == ST_LAUNCH) ? grant_oh : '0;
  assign GRANT_ACTIVE  = (state == ST_LAUNCH) || (state == ST_WAIT_BUSY) || (state == ST_WAIT_DONE);
  assign TX_P_DATA     = tx_data;
  assign GRANT_ID      = grant_id;
  assign TIMEOUT_ERR   = timeout_err;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with a byte-level UART TX model and a
// scoreboard of expected grants/bytes popped at each launch and line completion.
module tb_uart_tx_arbiter;

  localparam int N   = 4;
  localparam int DW  = 8;
  localparam int BUSY_LEN = 5;

  typedef struct packed {
    logic [1:0] id;
    logic [7:0] data;
  } frame_t;

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  req_valid;
  logic [N*DW-1:0] req_data;
  logic [N-1:0]  req_ack;
  logic          tx_busy;
  logic [DW-1:0] tx_p_data;
  logic          tx_data_valid;
  logic [1:0]    grant_id;
  logic          grant_active;
  logic          timeout_err;

  logic          hold_busy;
  logic          model_en;
  logic          m_busy = 1'b0;
  logic          m_pend = 1'b0;
  int            m_cnt = 0;
  logic [7:0]    m_byte = 8'h00;
  logic          line_vld = 1'b0;
  logic [7:0]    line_byte = 8'h00;

  int         n_cmp = 0;
  int         n_bad = 0;
  int         cyc_n = 0;
  frame_t     exp_q[$];
  logic [7:0] exp_line_q[$];
  logic [N-1:0] refill;
  logic       prev_busy;
  logic       prev_active;
  int         fall_cyc;
  bit         fall_vld;
  int         launch_cyc;
  int         to_cyc;

  always #5 clk = ~clk;

  assign tx_busy = m_busy | hold_busy;

  // UART TX model: busy rises two cycles after the launch pulse, lasts BUSY_LEN cycles.
  always @(posedge clk) begin
    line_vld <= 1'b0;
    if (m_pend) begin
      m_pend <= 1'b0;
      m_busy <= 1'b1;
      m_cnt  <= 0;
    end else if (m_busy) begin
      if (m_cnt == BUSY_LEN - 1) begin
        m_busy    <= 1'b0;
        line_vld  <= 1'b1;
        line_byte <= m_byte;
      end else begin
        m_cnt <= m_cnt + 1;
      end
    end else if (tx_data_valid && model_en) begin
      m_byte <= tx_p_data;
      m_pend <= 1'b1;
    end
  end

  uart_tx_arbiter #(
    .N_REQ        (N),
    .DATA_WIDTH   (DW),
    .BUSY_TIMEOUT (8),
    .IFG_CYCLES   (2)
  ) dut (
    .CLK           (clk),
    .RST           (rst),
    .REQ_VALID     (req_valid),
    .REQ_DATA      (req_data),
    .REQ_ACK       (req_ack),
    .TX_BUSY       (tx_busy),
    .TX_P_DATA     (tx_p_data),
    .TX_DATA_VALID (tx_data_valid),
    .GRANT_ID      (grant_id),
    .GRANT_ACTIVE  (grant_active),
    .TIMEOUT_ERR   (timeout_err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic expect_frame(input int id, input logic [7:0] d, input bit on_line);
    frame_t f;
    f.id   = id[1:0];
    f.data = d;
    exp_q.push_back(f);
    if (on_line) exp_line_q.push_back(d);
  endtask

  // One clock: sample at the falling edge, score launches/line bytes, run requester handshake.
  task automatic cyc();
    frame_t     f;
    logic [3:0] oh;
    logic [7:0] lb;
    @(negedge clk);
    cyc_n++;
    if (tx_data_valid) begin
      launch_cyc = cyc_n;
      check("launch_expected", exp_q.size() > 0, 1);
      if (exp_q.size() > 0) begin
        f  = exp_q.pop_front();
        oh = 4'b0001 << f.id;
        check("grant_id", grant_id, f.id);
        check("tx_p_data", tx_p_data, f.data);
        check("req_ack", req_ack, oh);
      end
      if (fall_vld) begin
        check("ifg_gap_ge3", (cyc_n - fall_cyc) >= 3, 1);
        fall_vld = 0;
      end
    end else begin
      check("ack_idle", req_ack, 0);
    end
    if (line_vld) begin
      check("line_expected", exp_line_q.size() > 0, 1);
      if (exp_line_q.size() > 0) begin
        lb = exp_line_q.pop_front();
        check("uart_line", line_byte, lb);
      end
    end
    if (prev_busy && !tx_busy) begin
      fall_vld = prev_active;
      fall_cyc = cyc_n;
    end
    prev_busy   = tx_busy;
    prev_active = grant_active;
    if (timeout_err) to_cyc = cyc_n;
    for (int i = 0; i < N; i++) begin
      if (req_ack[i]) begin
        if (refill[i]) req_data[i*DW +: DW] = req_data[i*DW +: DW] + 8'h40;
        else           req_valid[i] = 1'b0;
      end
    end
  endtask

  task automatic wait_quiet(input string tag);
    bit done;
    done = 0;
    for (int k = 0; k < 300 && !done; k++) begin
      cyc();
      if (exp_q.size() == 0 && exp_line_q.size() == 0 && !tx_busy && !grant_active && req_valid == 0)
        done = 1;
    end
    check({tag, "_quiet"}, done, 1);
    for (int k = 0; k < 4; k++) cyc();
  endtask

  initial begin
    bit seen;
    rst       = 1'b0;
    req_valid = '0;
    req_data  = '0;
    hold_busy = 1'b0;
    model_en  = 1'b1;
    refill    = '0;
    prev_busy = 1'b0;
    prev_active = 1'b0;
    fall_vld  = 0;
    fall_cyc  = 0;
    launch_cyc = 0;
    to_cyc    = -1;
    #1 rst = 1'b1;
    cyc();
    check("rst_tx_data_valid", tx_data_valid, 0);
    check("rst_req_ack", req_ack, 0);
    check("rst_tx_p_data", tx_p_data, 0);
    check("rst_grant_id", grant_id, 0);
    check("rst_grant_active", grant_active, 0);
    check("rst_timeout_err", timeout_err, 0);
    rst = 1'b0;
    cyc();

    // 1: single request, one-cycle launch latency, data stable after sampling
    req_data[15:8] = 8'hA5;
    req_valid      = 4'b0010;
    expect_frame(1, 8'hA5, 1);
    cyc();
    check("t1_launch_latency", tx_data_valid, 1);
    check("t1_grant_active", grant_active, 1);
    req_data[15:8] = 8'hFF;
    cyc();
    check("t1_data_stable", tx_p_data, 8'hA5);
    wait_quiet("t1");

    // 2: all four from reset, held continuously; two full rotations
    rst       = 1'b1;
    req_data  = 32'h13121110;
    req_valid = 4'b1111;
    refill    = 4'b1111;
    cyc();
    rst = 1'b0;
    for (int k = 0; k < 8; k++) expect_frame(k % 4, 8'h10 + 8'(k % 4) + ((k >= 4) ? 8'h40 : 8'h00), 1);
    seen = 0;
    for (int k = 0; k < 200 && !seen; k++) begin
      cyc();
      if (exp_q.size() == 4) seen = 1;
    end
    check("t2_first_rotation", seen, 1);
    refill = '0;
    wait_quiet("t2");

    // 3: pointer at 1 with 4'b1001 -> 3 then 0, data[0] updated after grant 3
    req_data[7:0] = 8'h21;
    req_valid     = 4'b0001;
    expect_frame(0, 8'h21, 1);
    wait_quiet("t3a");
    req_data[7:0]   = 8'h30;
    req_data[31:24] = 8'h33;
    req_valid       = 4'b1001;
    expect_frame(3, 8'h33, 1);
    expect_frame(0, 8'h77, 1);
    seen = 0;
    for (int k = 0; k < 50 && !seen; k++) begin
      cyc();
      if (exp_q.size() == 1) seen = 1;
    end
    check("t3_grant3_first", seen, 1);
    req_data[7:0] = 8'h77;
    wait_quiet("t3b");

    // 4: TX_BUSY never rises -> timeout 8 cycles after launch, then normal service
    model_en        = 1'b0;
    req_data[23:16] = 8'h3C;
    req_valid       = 4'b0100;
    expect_frame(2, 8'h3C, 0);
    to_cyc = -1;
    cyc();
    check("t4_launch", tx_data_valid, 1);
    for (int k = 0; k < 20 && to_cyc < 0; k++) cyc();
    check("t4_timeout_delay", to_cyc - launch_cyc, 8);
    check("t4_idle_at_timeout", grant_active, 0);
    cyc();
    check("t4_pulse_width", timeout_err, 0);
    model_en      = 1'b1;
    req_data[7:0] = 8'h5A;
    req_valid     = 4'b0001;
    expect_frame(0, 8'h5A, 1);
    wait_quiet("t4");

    // 5: reset during WAIT_DONE with TX still busy
    req_data[15:8] = 8'h66;
    req_valid      = 4'b0010;
    expect_frame(1, 8'h66, 1);
    seen = 0;
    for (int k = 0; k < 20 && !seen; k++) begin
      cyc();
      if (tx_busy && grant_active) seen = 1;
    end
    check("t5_reached_wait_done", seen, 1);
    hold_busy = 1'b1;
    rst       = 1'b1;
    #1;
    check("t5_rst_valid", tx_data_valid, 0);
    check("t5_rst_ack", req_ack, 0);
    check("t5_rst_active", grant_active, 0);
    check("t5_rst_grant_id", grant_id, 0);
    check("t5_rst_p_data", tx_p_data, 0);
    check("t5_rst_timeout", timeout_err, 0);
    cyc();
    rst = 1'b0;
    req_data[15:8]  = 8'h71;
    req_data[23:16] = 8'h72;
    req_valid       = 4'b0110;
    for (int k = 0; k < 10; k++) begin
      cyc();
      check("t5_no_launch_busy", tx_data_valid, 0);
    end
    expect_frame(1, 8'h71, 1);
    expect_frame(2, 8'h72, 1);
    hold_busy = 1'b0;
    cyc();
    check("t5_launch_after_busy", tx_data_valid, 1);
    wait_quiet("t5");

    // 6: TX busy at reset release, single pending request
    hold_busy       = 1'b1;
    rst             = 1'b1;
    req_data[23:16] = 8'h6C;
    req_valid       = 4'b0100;
    cyc();
    rst = 1'b0;
    for (int k = 0; k < 5; k++) begin
      cyc();
      check("t6_no_launch_busy", tx_data_valid, 0);
    end
    expect_frame(2, 8'h6C, 1);
    hold_busy = 1'b0;
    cyc();
    check("t6_launch_after_busy", tx_data_valid, 1);
    wait_quiet("t6");

    check("queues_drained", exp_q.size() + exp_line_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
